// File: rtl/ex_stage_muldiv_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: ID/EX operands, controls and forwarding
// selects go in; the EX/MEM register, hazard-unit copies and the stall come out.
interface ex_stage_muldiv_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  IDEXValid;
    logic [2:0]            IDEXExOp;
    logic                  IDEXRegDst;
    logic                  IDEXALUSrc;
    logic                  IDEXRegWrite;
    logic                  IDEXMemtoReg;
    logic                  IDEXMemRead;
    logic                  IDEXMemWrite;
    logic [WIDTH-1:0]      IDEXReadData1;
    logic [WIDTH-1:0]      IDEXReadData2;
    logic [WIDTH-1:0]      IDEXImm;
    logic [REG_ADDR_W-1:0] IDEXRs;
    logic [REG_ADDR_W-1:0] IDEXRt;
    logic [REG_ADDR_W-1:0] IDEXRd;
    logic [1:0]            ForwardA;
    logic [1:0]            ForwardB;
    logic [WIDTH-1:0]      MEMForwarding;
    logic [WIDTH-1:0]      WBForwarding;
    logic                  EXFlush;

    logic                  EXStall;
    logic                  IDEXMemReadOut;
    logic                  IDEXRegWriteOut;
    logic [REG_ADDR_W-1:0] EXDst;
    logic [REG_ADDR_W-1:0] IDEXRsOut;
    logic [REG_ADDR_W-1:0] IDEXRtOut;
    logic                  EXMEMRegWrite;
    logic                  EXMEMMemtoReg;
    logic                  EXMEMMemRead;
    logic                  EXMEMMemWrite;
    logic [WIDTH-1:0]      EXMEMReadAddress;
    logic [WIDTH-1:0]      EXMEMWriteData;
    logic [REG_ADDR_W-1:0] EXMEMDst;

    modport master (
        output IDEXValid, IDEXExOp, IDEXRegDst, IDEXALUSrc, IDEXRegWrite, IDEXMemtoReg,
               IDEXMemRead, IDEXMemWrite, IDEXReadData1, IDEXReadData2, IDEXImm,
               IDEXRs, IDEXRt, IDEXRd, ForwardA, ForwardB, MEMForwarding, WBForwarding,
               EXFlush,
        input  EXStall, IDEXMemReadOut, IDEXRegWriteOut, EXDst, IDEXRsOut, IDEXRtOut,
               EXMEMRegWrite, EXMEMMemtoReg, EXMEMMemRead, EXMEMMemWrite,
               EXMEMReadAddress, EXMEMWriteData, EXMEMDst
    );

    modport slave (
        input  IDEXValid, IDEXExOp, IDEXRegDst, IDEXALUSrc, IDEXRegWrite, IDEXMemtoReg,
               IDEXMemRead, IDEXMemWrite, IDEXReadData1, IDEXReadData2, IDEXImm,
               IDEXRs, IDEXRt, IDEXRd, ForwardA, ForwardB, MEMForwarding, WBForwarding,
               EXFlush,
        output EXStall, IDEXMemReadOut, IDEXRegWriteOut, EXDst, IDEXRsOut, IDEXRtOut,
               EXMEMRegWrite, EXMEMMemtoReg, EXMEMMemRead, EXMEMMemWrite,
               EXMEMReadAddress, EXMEMWriteData, EXMEMDst
    );
endinterface

// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier that stalls
// the front end while it works, feeding the EX/MEM pipeline register.
module ex_stage_muldiv #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic               clock,
    input logic               resetN,
    ex_stage_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } ex_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WIDTH-1:0]      mcand_q;
    logic [WIDTH-1:0]      mplier_q;
    logic [WIDTH-1:0]      acc_q;
    logic [WIDTH-1:0]      store_q;

    logic [3:0]            exmem_ctrl_q;
    logic [WIDTH-1:0]      exmem_addr_q;
    logic [WIDTH-1:0]      exmem_wdata_q;
    logic [REG_ADDR_W-1:0] exmem_dst_q;

    ex_op_e                op;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      fwd_b;
    logic [WIDTH-1:0]      op_b;
    logic [WIDTH-1:0]      alu_result_d;
    logic [3:0]            ctrl_d;
    logic [REG_ADDR_W-1:0] dst_d;
    logic                  mul_issue;

    assign op = ex_op_e'(bus.IDEXExOp);

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        op_a = bus.IDEXReadData1;
        case (bus.ForwardA)
            2'b10:   op_a = bus.MEMForwarding;
            2'b01:   op_a = bus.WBForwarding;
            default: op_a = bus.IDEXReadData1;
        endcase
        fwd_b = bus.IDEXReadData2;
        case (bus.ForwardB)
            2'b10:   fwd_b = bus.MEMForwarding;
            2'b01:   fwd_b = bus.WBForwarding;
            default: fwd_b = bus.IDEXReadData2;
        endcase
    end

    assign op_b = bus.IDEXALUSrc ? bus.IDEXImm : fwd_b;

    always_comb begin
        alu_result_d = op_a + op_b;
        case (op)
            OP_SUB:  alu_result_d = op_a - op_b;
            OP_AND:  alu_result_d = op_a & op_b;
            OP_OR:   alu_result_d = op_a | op_b;
            OP_NOR:  alu_result_d = ~(op_a | op_b);
            OP_SLT:  alu_result_d = WIDTH'($signed(op_a) < $signed(op_b));
            default: alu_result_d = op_a + op_b;
        endcase
    end

    assign dst_d     = bus.IDEXRegDst ? bus.IDEXRd : bus.IDEXRt;
    assign ctrl_d    = bus.IDEXValid ? {bus.IDEXRegWrite, bus.IDEXMemtoReg,
                                        bus.IDEXMemRead, bus.IDEXMemWrite} : 4'b0000;
    assign mul_issue = bus.IDEXValid && (op == OP_MUL) && !bus.EXFlush;

    // Stall covers the issue cycle too, so upstream freezes before the operands move on.
    assign bus.EXStall = resetN && ((state_q == S_BUSY) || ((state_q == S_IDLE) && mul_issue));

    // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
    // reset as well so an aborted multiply leaves nothing behind.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            store_q       <= '0;
            exmem_ctrl_q  <= '0;
            exmem_addr_q  <= '0;
            exmem_wdata_q <= '0;
            exmem_dst_q   <= '0;
        end else begin
            exmem_ctrl_q  <= '0;
            exmem_addr_q  <= '0;
            exmem_wdata_q <= '0;
            exmem_dst_q   <= '0;
            if (bus.EXFlush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (mul_issue) begin
                            state_q  <= S_BUSY;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            mcand_q  <= op_a;
                            mplier_q <= op_b;
                            store_q  <= fwd_b;
                        end else if (bus.IDEXValid) begin
                            exmem_ctrl_q  <= ctrl_d;
                            exmem_addr_q  <= alu_result_d;
                            exmem_wdata_q <= fwd_b;
                            exmem_dst_q   <= dst_d;
                        end
                    end
                    S_BUSY: begin
                        acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_DONE;
                    end
                    S_DONE: begin
                        exmem_ctrl_q  <= ctrl_d;
                        exmem_addr_q  <= acc_q;
                        exmem_wdata_q <= store_q;
                        exmem_dst_q   <= dst_d;
                        state_q       <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.IDEXMemReadOut   = bus.IDEXMemRead;
    assign bus.IDEXRegWriteOut  = bus.IDEXRegWrite;
    assign bus.EXDst            = dst_d;
    assign bus.IDEXRsOut        = bus.IDEXRs;
    assign bus.IDEXRtOut        = bus.IDEXRt;
    assign bus.EXMEMRegWrite    = exmem_ctrl_q[3];
    assign bus.EXMEMMemtoReg    = exmem_ctrl_q[2];
    assign bus.EXMEMMemRead     = exmem_ctrl_q[1];
    assign bus.EXMEMMemWrite    = exmem_ctrl_q[0];
    assign bus.EXMEMReadAddress = exmem_addr_q;
    assign bus.EXMEMWriteData   = exmem_wdata_q;
    assign bus.EXMEMDst         = exmem_dst_q;
endmodule
